ecpri_frame_sched: RTL and testbench
====================================

# ecpri_frame_sched

Frame-level controller that sequences the eCPRI receive/response datapath. It queues frame descriptors for frames already written into the Ethernet receive RAM and drives `recv_pkt` to `ecpri_rx` for exactly one frame at a time. It then triggers `ecpri_tx` when the receiver requests a write or read response, and hands the finished response packet to the Ethernet transmit side through a valid/ack handshake. It sits between the MAC-side RAM writer and the `ecpri_rx`/`ecpri_tx` pair, and owns all per-frame timing that is otherwise hand-driven.

## Interface
- `ADDR_WIDTH`, 16, RAM address width
- `DATA_WIDTH`, 8, RAM data width; also the width of `resp_payload_len`
- `QDEPTH`, 4, descriptor FIFO entries (power of 2, ≥2)
- `RESP_WINDOW`, 64, cycles to wait for a response request after the frame ends
- `TX_TIMEOUT`, 1024, cycles to wait for `cpri_pkt_rdy_flg`

Ports:
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-low (0 = reset)
- `frm_valid` in 1 — descriptor offered
- `frm_base` in ADDR_WIDTH — frame start address in the Ethernet receive RAM
- `frm_len` in 16 — frame length in bytes
- `frm_ready` out 1 — descriptor FIFO not full
- `rx_base` out ADDR_WIDTH — base address of the active frame, for `ecpri_rx`
- `recv_pkt` out 1 — frame-processing strobe to `ecpri_rx`/`ecpri_tx`
- `send_write_resp`, `send_read_resp` in 1 — response requests from `ecpri_rx`
- `resp_payload_len` in DATA_WIDTH — response payload length from `ecpri_rx`
- `tx_start` out 1 — one-cycle start pulse to `ecpri_tx`
- `cpri_pkt_rdy_flg` in 1 — response packet built
- `resp_valid` out 1; `resp_ack` in 1 — response handoff to Ethernet TX
- `resp_len` out 16 — response payload length
- `resp_is_read` out 1 — 1 = read response, 0 = write response
- `busy` out 1 — state ≠ IDLE or FIFO non-empty
- `cnt_frames`, `cnt_resp`, `cnt_noresp`, `cnt_timeout` out 16 each — saturating counters

## Operation
- Descriptor push on `frm_valid && frm_ready`. `frm_ready = !full`, where `full` is the registered state, so a same-cycle pop never frees a slot for the push in that cycle.
- FSM states: IDLE, LOAD, RX_RUN, RX_WAIT, TX_START, TX_WAIT, RESP, DONE.
- IDLE: FIFO non-empty → LOAD.
- LOAD:
  - Register head `frm_base` → `rx_base` and `frm_len` → length counter.
  - `frm_len == 0`: skip to DONE, no `recv_pkt`, count in `cnt_noresp`.
  - Otherwise → RX_RUN.
- RX_RUN:
  - `recv_pkt = 1` for exactly `frm_len` cycles; counter decrements each cycle.
  - Then → RX_WAIT with the window counter loaded to `RESP_WINDOW`.
- Response latch, active in RX_RUN and RX_WAIT:
  - The first cycle where `send_write_resp || send_read_resp` is high captures `resp_is_read` and `resp_payload_len`, zero-extended to 16 bits.
  - Both high in the same cycle → write response wins (`resp_is_read = 0`).
  - Later requests in the same frame are ignored.
- RX_WAIT:
  - Latch set → TX_START. A latch set during RX_RUN passes through RX_WAIT for one cycle.
  - Window expires with no request → DONE, `cnt_noresp++`.
- TX_START: `tx_start = 1` for one cycle → TX_WAIT, timeout counter loaded to `TX_TIMEOUT`.
- TX_WAIT:
  - `cpri_pkt_rdy_flg` → RESP.
  - Timeout → DONE, `cnt_timeout++`, no `resp_valid`.
- RESP: `resp_valid = 1`, holding `resp_len` and `resp_is_read` stable until `resp_ack`. On ack → DONE, `cnt_resp++`.
- DONE: pop the head, `cnt_frames++`, clear the latch → IDLE.
- Counters stop at 0xFFFF.
- Reset low at any time, including mid-frame:
  - FIFO flushed, state IDLE.
  - All outputs and counters 0; `frm_ready` goes to 1 once `reset` is high.

## Timing
- Reset values: `recv_pkt`, `tx_start`, `resp_valid`, `resp_is_read`, `busy` = 0; `rx_base`, `resp_len`, all counters = 0.
- All outputs are registered except `frm_ready`.
- Push into an empty FIFO at edge k → LOAD after k+1 → `recv_pkt` high after k+2 through k+1+`frm_len`.
- Request seen at edge m in RX_WAIT → `tx_start` high during cycle m+1.
- `cpri_pkt_rdy_flg` at edge n → `resp_valid` high after n+1. `resp_ack` accepted on the edge where `resp_valid` is high.
- Back-to-back frames: at least 2 idle cycles between `recv_pkt` windows (DONE, IDLE→LOAD).
- The FIFO pointer wrap uses an extra MSB to separate full from empty.

## Structure
- Package `ecpri_pkg`: state enum `sched_state_t`, default parameter constants, and the descriptor struct `{base, len}`.
- One sub-module, `sched_desc_fifo`: synchronous FIFO with `QDEPTH` entries, asynchronous active-low reset, registered full/empty.

## Test plan
- Single frame, base 0x0000, len 48; `send_write_resp` 10 cycles after `recv_pkt` falls; `resp_payload_len = 0x10`; `cpri_pkt_rdy_flg` 5 cycles after `tx_start`. Required: `recv_pkt` high exactly 48 cycles, one `tx_start` pulse, `resp_valid` with `resp_len = 16` and `resp_is_read = 0`, `cnt_resp = 1`.
- Push 5 descriptors back-to-back with `QDEPTH = 4`. Required: `frm_ready` low after the 4th push; all 4 queued frames processed in order; the 5th is accepted only after the first pop.
- No response request. Required: DONE after len + 64 cycles, `cnt_noresp = 1`, no `tx_start`.
- Write and read requests in the same cycle. Required: `resp_is_read = 0`. Separately, `cpri_pkt_rdy_flg` never asserted: `cnt_timeout = 1` after 1024 cycles, no `resp_valid`.
- `reset` low during RX_RUN of a frame with 2 more queued. Required: `recv_pkt` drops immediately, FIFO empty, counters 0, `frm_ready = 1` after release. Also `frm_len = 0`: popped with no `recv_pkt` pulse.

Source files
------------

// File: rtl/ecpri_frame_sched_pkg.sv
// Shared types and defaults for the eCPRI frame scheduler: FSM states, descriptor layout, saturating counter helper.
// Pure declarations; no timing or flow control of its own.
package ecpri_pkg;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_QDEPTH      = 4;
  localparam int DEF_RESP_WINDOW = 64;
  localparam int DEF_TX_TIMEOUT  = 1024;
  // Descriptor base field is sized for the default RAM address width.
  localparam int DESC_BASE_W     = DEF_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, LOAD, RX_RUN, RX_WAIT, TX_START, TX_WAIT, RESP, DONE
  } sched_state_t;

  typedef struct packed {
    logic [DESC_BASE_W-1:0] base;
    logic [15:0]            len;
  } desc_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/ecpri_frame_sched_if.sv
// Bundles the descriptor, ecpri_rx/ecpri_tx control, response handoff and statistics signals.
// slave = scheduler side, master = MAC writer / rx / tx / Ethernet TX side.
interface ecpri_frame_sched_if
  import ecpri_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  frm_valid;
  logic [ADDR_WIDTH-1:0] frm_base;
  logic [15:0]           frm_len;
  logic                  frm_ready;
  logic [ADDR_WIDTH-1:0] rx_base;
  logic                  recv_pkt;
  logic                  send_write_resp;
  logic                  send_read_resp;
  logic [DATA_WIDTH-1:0] resp_payload_len;
  logic                  tx_start;
  logic                  cpri_pkt_rdy_flg;
  logic                  resp_valid;
  logic                  resp_ack;
  logic [15:0]           resp_len;
  logic                  resp_is_read;
  logic                  busy;
  logic [15:0]           cnt_frames;
  logic [15:0]           cnt_resp;
  logic [15:0]           cnt_noresp;
  logic [15:0]           cnt_timeout;

  modport slave (
    input  frm_valid, frm_base, frm_len, send_write_resp, send_read_resp,
           resp_payload_len, cpri_pkt_rdy_flg, resp_ack,
    output frm_ready, rx_base, recv_pkt, tx_start, resp_valid, resp_len,
           resp_is_read, busy, cnt_frames, cnt_resp, cnt_noresp, cnt_timeout
  );

  modport master (
    output frm_valid, frm_base, frm_len, send_write_resp, send_read_resp,
           resp_payload_len, cpri_pkt_rdy_flg, resp_ack,
    input  frm_ready, rx_base, recv_pkt, tx_start, resp_valid, resp_len,
           resp_is_read, busy, cnt_frames, cnt_resp, cnt_noresp, cnt_timeout
  );
endinterface

// File: rtl/ecpri_frame_sched_desc_fifo.sv
// Descriptor FIFO, QDEPTH entries; push visible at head one cycle later.
// Registered full/empty: a pop never frees a slot for a push in the same cycle.
module sched_desc_fifo
  import ecpri_pkg::*;
#(
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_push,
  input  desc_t i_dat,
  input  logic  i_pop,
  output desc_t o_dat,
  output logic  o_full,
  output logic  o_empty
);
  localparam int AW = $clog2(QDEPTH);

  desc_t         r_mem [QDEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic [AW:0]   w_wp_n, w_rp_n;
  logic          r_full, r_empty;
  logic          w_push, w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;
  assign w_wp_n = r_wp + {{AW{1'b0}}, w_push};
  assign w_rp_n = r_rp + {{AW{1'b0}}, w_pop};

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wp    <= w_wp_n;
      r_rp    <= w_rp_n;
      r_full  <= (w_wp_n[AW] != w_rp_n[AW]) && (w_wp_n[AW-1:0] == w_rp_n[AW-1:0]);
      r_empty <= (w_wp_n == w_rp_n);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_dat;
  end

  assign o_dat   = r_mem[r_rp[AW-1:0]];
  assign o_full  = r_full;
  assign o_empty = r_empty;
endmodule

// File: rtl/ecpri_frame_sched.sv
// Sequences one queued frame at a time through ecpri_rx/ecpri_tx and hands the response to Ethernet TX.
// Outputs registered (frm_ready excepted); response held on resp_valid until resp_ack.
module ecpri_frame_sched
  import ecpri_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int QDEPTH      = DEF_QDEPTH,
  parameter int RESP_WINDOW = DEF_RESP_WINDOW,
  parameter int TX_TIMEOUT  = DEF_TX_TIMEOUT
) (
  input logic               clk,
  input logic               reset,
  ecpri_frame_sched_if.slave bus
);
  localparam logic [15:0] WIN_INIT = 16'(RESP_WINDOW);
  localparam logic [15:0] TO_INIT  = 16'(TX_TIMEOUT);

  sched_state_t          r_state, w_state_n;
  desc_t                 w_push_dat, w_head;
  logic                  w_full, w_empty, w_pop;
  logic                  w_noresp, w_timeout, w_resp_done;
  logic [15:0]           r_len_cnt, r_wait_cnt;
  logic                  r_lat_vld, r_pkt_rdy;
  logic                  r_recv_pkt, r_tx_start, r_resp_valid, r_resp_is_read, r_busy;
  logic [ADDR_WIDTH-1:0] r_rx_base;
  logic [15:0]           r_resp_len;
  logic [15:0]           r_cnt_frames, r_cnt_resp, r_cnt_noresp, r_cnt_timeout;

  assign w_push_dat.base = DESC_BASE_W'(bus.frm_base);
  assign w_push_dat.len  = bus.frm_len;

  sched_desc_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.frm_valid),
    .i_dat   (w_push_dat),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n   = r_state;
    w_pop       = 1'b0;
    w_noresp    = 1'b0;
    w_timeout   = 1'b0;
    w_resp_done = 1'b0;
    case (r_state)
      IDLE:     if (!w_empty) w_state_n = LOAD;
      LOAD: begin
        if (w_head.len == 16'd0) begin
          w_state_n = DONE;
          w_noresp  = 1'b1;
        end else begin
          w_state_n = RX_RUN;
        end
      end
      RX_RUN:   if (r_len_cnt == 16'd1) w_state_n = RX_WAIT;
      RX_WAIT: begin
        if (r_lat_vld) begin
          w_state_n = TX_START;
        end else if (r_wait_cnt == 16'd1) begin
          w_state_n = DONE;
          w_noresp  = 1'b1;
        end
      end
      TX_START: w_state_n = TX_WAIT;
      TX_WAIT: begin
        if (r_pkt_rdy) begin
          w_state_n = RESP;
        end else if (r_wait_cnt == 16'd1) begin
          w_state_n = DONE;
          w_timeout = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ack) begin
          w_state_n   = DONE;
          w_resp_done = 1'b1;
        end
      end
      DONE: begin
        w_pop     = 1'b1;
        w_state_n = IDLE;
      end
      default:  w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_recv_pkt     <= 1'b0;
      r_tx_start     <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_busy         <= 1'b0;
      r_pkt_rdy      <= 1'b0;
      r_rx_base      <= '0;
      r_len_cnt      <= '0;
      r_wait_cnt     <= '0;
      r_lat_vld      <= 1'b0;
      r_resp_is_read <= 1'b0;
      r_resp_len     <= '0;
      r_cnt_frames   <= '0;
      r_cnt_resp     <= '0;
      r_cnt_noresp   <= '0;
      r_cnt_timeout  <= '0;
    end else begin
      // Strobes follow the next state so they line up with the state they belong to.
      r_recv_pkt   <= (w_state_n == RX_RUN);
      r_tx_start   <= (w_state_n == TX_START);
      r_resp_valid <= (w_state_n == RESP);
      r_busy       <= (w_state_n != IDLE) || !w_empty;
      r_pkt_rdy    <= bus.cpri_pkt_rdy_flg && (r_state == TX_WAIT);

      case (r_state)
        LOAD: begin
          r_rx_base <= ADDR_WIDTH'(w_head.base);
          r_len_cnt <= w_head.len;
        end
        RX_RUN: begin
          r_len_cnt <= r_len_cnt - 16'd1;
          if (r_len_cnt == 16'd1) r_wait_cnt <= WIN_INIT;
        end
        RX_WAIT:  r_wait_cnt <= r_wait_cnt - 16'd1;
        TX_START: r_wait_cnt <= TO_INIT;
        TX_WAIT:  r_wait_cnt <= r_wait_cnt - 16'd1;
        default: ;
      endcase

      // First request of the frame wins; a simultaneous write beats read.
      if (r_state == DONE) begin
        r_lat_vld <= 1'b0;
      end else if ((r_state == RX_RUN || r_state == RX_WAIT) && !r_lat_vld &&
                   (bus.send_write_resp || bus.send_read_resp)) begin
        r_lat_vld      <= 1'b1;
        r_resp_is_read <= !bus.send_write_resp;
        r_resp_len     <= 16'(bus.resp_payload_len);
      end

      if (r_state == DONE) r_cnt_frames  <= sat_inc(r_cnt_frames);
      if (w_resp_done)     r_cnt_resp    <= sat_inc(r_cnt_resp);
      if (w_noresp)        r_cnt_noresp  <= sat_inc(r_cnt_noresp);
      if (w_timeout)       r_cnt_timeout <= sat_inc(r_cnt_timeout);
    end
  end

  assign bus.frm_ready    = !w_full && reset;
  assign bus.rx_base      = r_rx_base;
  assign bus.recv_pkt     = r_recv_pkt;
  assign bus.tx_start     = r_tx_start;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_len     = r_resp_len;
  assign bus.resp_is_read = r_resp_is_read;
  assign bus.busy         = r_busy;
  assign bus.cnt_frames   = r_cnt_frames;
  assign bus.cnt_resp     = r_cnt_resp;
  assign bus.cnt_noresp   = r_cnt_noresp;
  assign bus.cnt_timeout  = r_cnt_timeout;
endmodule

// File: tb/tb_ecpri_frame_sched.sv
// Directed bench for ecpri_frame_sched: single response, queue full, no response, write/read priority,
// tx timeout, read response, mid-frame reset and zero-length frame.
module tb_ecpri_frame_sched;
  import ecpri_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ecpri_frame_sched_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  ecpri_frame_sched #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .QDEPTH(4), .RESP_WINDOW(64), .TX_TIMEOUT(1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic        prev_recv = 1'b0;
  int          recv_cycles = 0;
  int          tx_pulses = 0;
  int          rv_cycles = 0;
  logic [15:0] base_q[$];

  always @(negedge clk) begin
    if (bus.recv_pkt) recv_cycles++;
    if (bus.recv_pkt && !prev_recv) base_q.push_back(bus.rx_base);
    if (bus.tx_start) tx_pulses++;
    if (bus.resp_valid) rv_cycles++;
    prev_recv = bus.recv_pkt;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // sel: 0 recv_pkt, 1 tx_start, 2 resp_valid, 3 busy
  task automatic wait_sig(input string tag, input int sel, input logic lvl, input int budget, output int n);
    logic s;
    n = 0;
    forever begin
      case (sel)
        0:       s = bus.recv_pkt;
        1:       s = bus.tx_start;
        2:       s = bus.resp_valid;
        default: s = bus.busy;
      endcase
      if (s === lvl) break;
      if (n >= budget) begin
        chk({tag, "_timeout"}, 32'(s), 32'(lvl));
        break;
      end
      step();
      n++;
    end
  endtask

  task automatic push(input logic [15:0] base, input logic [15:0] len);
    int n = 0;
    while (bus.frm_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    bus.frm_valid = 1'b1;
    bus.frm_base  = base;
    bus.frm_len   = len;
    step();
    bus.frm_valid = 1'b0;
  endtask

  task automatic ack_resp();
    bus.resp_ack = 1'b1;
    step();
    bus.resp_ack = 1'b0;
  endtask

  initial begin
    int          n;
    int          snap;
    logic [15:0] exp_base [5];
    exp_base = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104};

    reset                = 1'b0;
    bus.frm_valid        = 1'b0;
    bus.frm_base         = '0;
    bus.frm_len          = '0;
    bus.send_write_resp  = 1'b0;
    bus.send_read_resp   = 1'b0;
    bus.resp_payload_len = '0;
    bus.cpri_pkt_rdy_flg = 1'b0;
    bus.resp_ack         = 1'b0;

    // Reset state
    step(3);
    chk("rst_strobes", {bus.recv_pkt, bus.tx_start, bus.resp_valid, bus.resp_is_read, bus.busy}, 0);
    chk("rst_rx_base", bus.rx_base, 0);
    chk("rst_resp_len", bus.resp_len, 0);
    chk("rst_cnt_a", {bus.cnt_frames, bus.cnt_resp}, 0);
    chk("rst_cnt_b", {bus.cnt_noresp, bus.cnt_timeout}, 0);
    chk("rst_frm_ready", bus.frm_ready, 0);
    reset = 1'b1;
    step();
    chk("frm_ready_after_rst", bus.frm_ready, 1);

    // Single frame, write response
    push(16'h0000, 16'd48);
    wait_sig("t1_recv_hi", 0, 1'b1, 10, n);
    chk("t1_recv_latency", n, 2);
    wait_sig("t1_recv_lo", 0, 1'b0, 100, n);
    chk("t1_recv_len", n, 48);
    chk("t1_recv_cycles", recv_cycles, 48);
    step(9);
    bus.send_write_resp  = 1'b1;
    bus.resp_payload_len = 8'h10;
    step();
    bus.send_write_resp  = 1'b0;
    wait_sig("t1_txs", 1, 1'b1, 10, n);
    chk("t1_txs_latency", n, 1);
    step(4);
    bus.cpri_pkt_rdy_flg = 1'b1;
    step();
    bus.cpri_pkt_rdy_flg = 1'b0;
    wait_sig("t1_rv", 2, 1'b1, 10, n);
    chk("t1_rv_latency", n, 1);
    chk("t1_resp_len", bus.resp_len, 16);
    chk("t1_is_read", bus.resp_is_read, 0);
    step(2);
    chk("t1_rv_hold", {bus.resp_valid, bus.resp_len}, {1'b1, 16'd16});
    ack_resp();
    chk("t1_rv_drop", bus.resp_valid, 0);
    wait_sig("t1_idle", 3, 1'b0, 20, n);
    chk("t1_cnt_resp", bus.cnt_resp, 1);
    chk("t1_cnt_frames", bus.cnt_frames, 1);
    chk("t1_tx_pulses", tx_pulses, 1);
    chk("t1_cnt_noresp", bus.cnt_noresp, 0);

    // Five descriptors into a 4-deep queue, no responses
    base_q.delete();
    for (int i = 0; i < 4; i++) push(exp_base[i], 16'(3 + i));
    chk("t2_full", bus.frm_ready, 0);
    n = 0;
    while (bus.frm_ready !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    chk("t2_fifth_after_pop", bus.cnt_frames, 2);
    push(exp_base[4], 16'd7);
    wait_sig("t2_idle", 3, 1'b0, 1000, n);
    chk("t2_nframes", base_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), (i < base_q.size()) ? base_q[i] : 16'hDEAD, exp_base[i]);
    chk("t2_cnt_noresp", bus.cnt_noresp, 5);
    chk("t2_cnt_frames", bus.cnt_frames, 6);

    // No response: window length
    push(16'h0200, 16'd4);
    wait_sig("t3_recv_hi", 0, 1'b1, 10, n);
    wait_sig("t3_recv_lo", 0, 1'b0, 10, n);
    n = 0;
    while (bus.cnt_noresp == 16'd5 && n < 200) begin
      step();
      n++;
    end
    chk("t3_window", n, 64);
    chk("t3_no_txs", tx_pulses, 1);

    // Simultaneous write+read, later read ignored, tx never ready
    snap = rv_cycles;
    push(16'h0300, 16'd8);
    wait_sig("t4_recv_hi", 0, 1'b1, 10, n);
    step(2);
    bus.send_write_resp  = 1'b1;
    bus.send_read_resp   = 1'b1;
    bus.resp_payload_len = 8'h20;
    step();
    bus.send_write_resp  = 1'b0;
    bus.resp_payload_len = 8'h33;
    step();
    bus.send_read_resp   = 1'b0;
    wait_sig("t4_txs", 1, 1'b1, 100, n);
    chk("t4_is_read", bus.resp_is_read, 0);
    chk("t4_resp_len", bus.resp_len, 16'h20);
    n = 0;
    while (bus.cnt_timeout == 16'd0 && n < 1100) begin
      step();
      n++;
    end
    chk("t4_timeout_cycles", n, 1025);
    chk("t4_cnt_timeout", bus.cnt_timeout, 1);
    chk("t4_no_rv", rv_cycles, snap);

    // Read response
    push(16'h0400, 16'd2);
    wait_sig("t4b_recv_hi", 0, 1'b1, 10, n);
    bus.send_read_resp   = 1'b1;
    bus.resp_payload_len = 8'h05;
    step();
    bus.send_read_resp   = 1'b0;
    wait_sig("t4b_txs", 1, 1'b1, 100, n);
    step();
    bus.cpri_pkt_rdy_flg = 1'b1;
    step();
    bus.cpri_pkt_rdy_flg = 1'b0;
    wait_sig("t4b_rv", 2, 1'b1, 10, n);
    chk("t4b_resp", {bus.resp_is_read, bus.resp_len}, {1'b1, 16'd5});
    ack_resp();
    wait_sig("t4b_idle", 3, 1'b0, 20, n);
    chk("t4b_cnt_resp", bus.cnt_resp, 2);

    // Reset during RX_RUN with two more frames queued
    for (int i = 0; i < 3; i++) push(16'(16'h0500 + i), 16'd20);
    wait_sig("t5_recv_hi", 0, 1'b1, 10, n);
    step(5);
    reset = 1'b0;
    #1;
    chk("t5_recv_drop", bus.recv_pkt, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_cnt_a", {bus.cnt_frames, bus.cnt_resp}, 0);
    chk("t5_cnt_b", {bus.cnt_noresp, bus.cnt_timeout}, 0);
    step();
    reset = 1'b1;
    step();
    chk("t5_frm_ready", bus.frm_ready, 1);
    snap = base_q.size();
    step(10);
    chk("t5_flushed", base_q.size(), snap);
    chk("t5_idle", {bus.busy, bus.recv_pkt}, 0);

    // Zero-length frame
    snap = recv_cycles;
    push(16'h0055, 16'd0);
    n = 0;
    while (bus.cnt_frames == 16'd0 && n < 20) begin
      step();
      n++;
    end
    chk("t6_popped", bus.cnt_frames, 1);
    chk("t6_noresp", bus.cnt_noresp, 1);
    chk("t6_no_recv", recv_cycles, snap);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
